// File: rtl/host_link_pkg.sv
// Shared definitions for the host side of the stage controller byte protocol:
// message codes, link FSM states and per-round width helpers.
package host_link_pkg;

  localparam logic [7:0] START_DECODING_MSG      = 8'h01;
  localparam logic [7:0] MEASUREMENT_DATA_HEADER = 8'h02;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX_START,
    ST_TX_HDR,
    ST_TX_MEAS,
    ST_RX_RESP,
    ST_RESULT
  } state_e;

  function automatic int meas_bytes(input int x, input int z);
    return (x * z + 7) >> 3;
  endfunction

  // X- and Z-type edge corrections plus the boundary bit, per round
  function automatic int corr_bits(input int x, input int z);
    return (x - 1) * z + (x - 1) * z + 1 + x * z;
  endfunction

  function automatic int corr_bytes(input int x, input int z);
    return (corr_bits(x, z) + 7) >> 3;
  endfunction

endpackage

// File: rtl/host_link_byte_unpacker.sv
// Assembles received correction bytes into the per-round correction vector.
// Bits that fall past the per-round correction width are dropped.
module host_link_byte_unpacker
  import host_link_pkg::*;
#(
  parameter int GRID_WIDTH_X = 4,
  parameter int GRID_WIDTH_Z = 1,
  parameter int GRID_WIDTH_U = 3,
  parameter int RNDW         = 2,
  parameter int BYW          = 1
) (
  input  logic                                                      clk,
  input  logic                                                      reset_n,
  input  logic                                                      clear,
  input  logic                                                      wr_en,
  input  logic [RNDW-1:0]                                           round_idx,
  input  logic [BYW-1:0]                                            byte_idx,
  input  logic [7:0]                                                data,
  output logic [GRID_WIDTH_U*corr_bits(GRID_WIDTH_X,GRID_WIDTH_Z)-1:0] corr
);

  localparam int C  = corr_bits(GRID_WIDTH_X, GRID_WIDTH_Z);
  localparam int CW = GRID_WIDTH_U * C;

  logic [CW-1:0] corr_q, corr_d;

  always_comb begin
    corr_d = corr_q;
    if (clear) begin
      corr_d = '0;
    end else if (wr_en) begin
      for (int b = 0; b < 8; b++) begin
        if ((int'(byte_idx) * 8 + b < C) && (int'(round_idx) < GRID_WIDTH_U)) begin
          corr_d[int'(round_idx) * C + int'(byte_idx) * 8 + b] = data[b];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) corr_q <= '0;
    else          corr_q <= corr_d;
  end

  assign corr = corr_q;

endmodule

// File: rtl/decoder_host_link.sv
// Host-side peer of the stage controller: serialises one measurement job and
// collects the response. Optional response watchdog under HOST_LINK_TIMEOUT_EN.
module decoder_host_link
  import host_link_pkg::*;
#(
  parameter int GRID_WIDTH_X        = 4,
  parameter int GRID_WIDTH_Z        = 1,
  parameter int GRID_WIDTH_U        = 3,
  parameter int RESP_TIMEOUT_CYCLES = 1024
) (
  input  logic                                                         clk,
  input  logic                                                         reset_n,
  input  logic                                                         job_valid,
  output logic                                                         job_ready,
  input  logic [GRID_WIDTH_U*meas_bytes(GRID_WIDTH_X,GRID_WIDTH_Z)*8-1:0] job_meas,
  input  logic                                                         cfg_send_start,
  output logic [7:0]                                                   tx_data,
  output logic                                                         tx_valid,
  input  logic                                                         tx_ready,
  input  logic [7:0]                                                   rx_data,
  input  logic                                                         rx_valid,
  output logic                                                         rx_ready,
  output logic                                                         res_valid,
  input  logic                                                         res_ready,
  output logic [7:0]                                                   res_iterations,
  output logic [15:0]                                                  res_cycles,
  output logic [GRID_WIDTH_U*corr_bits(GRID_WIDTH_X,GRID_WIDTH_Z)-1:0]    res_corr,
  output logic                                                         res_timeout,
  output logic                                                         busy
);

  localparam int P        = GRID_WIDTH_X * GRID_WIDTH_Z;
  localparam int MB       = meas_bytes(GRID_WIDTH_X, GRID_WIDTH_Z);
  localparam int CB       = corr_bytes(GRID_WIDTH_X, GRID_WIDTH_Z);
  localparam int MW       = GRID_WIDTH_U * MB * 8;
  localparam int TX_BYTES = GRID_WIDTH_U * MB;
  localparam int RX_BYTES = 3 + GRID_WIDTH_U * CB;
  localparam int TXW      = $clog2(TX_BYTES + 1);
  localparam int RXW      = $clog2(RX_BYTES + 1);
  localparam int RNDW     = (GRID_WIDTH_U > 1) ? $clog2(GRID_WIDTH_U) : 1;
  localparam int BYW      = (CB > 1) ? $clog2(CB) : 1;

  localparam logic [TXW-1:0] TX_LAST = TXW'(TX_BYTES - 1);
  localparam logic [RXW-1:0] RX_LAST = RXW'(RX_BYTES - 1);

  state_e           state_q, state_d;
  logic [MW-1:0]    meas_q, meas_d, meas_masked;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic [TXW-1:0]   tx_cnt_q, tx_cnt_d;
  logic [RXW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [7:0]       res_iter_q, res_iter_d;
  logic [15:0]      res_cycles_q, res_cycles_d;
  logic             res_valid_q, res_valid_d;
  logic             tx_hs, rx_hs;
  logic             corr_clear, corr_wr;
  logic [RXW-1:0]   corr_idx;
  logic [RNDW-1:0]  corr_round;
  logic [BYW-1:0]   corr_byte;

`ifdef HOST_LINK_TIMEOUT_EN
  localparam int WDW = $clog2(RESP_TIMEOUT_CYCLES + 1);
  localparam logic [WDW-1:0] WD_LIMIT = WDW'(RESP_TIMEOUT_CYCLES);
  logic [WDW-1:0]   wdog_q, wdog_d;
  logic             res_tout_q, res_tout_d;
`endif

  // Pad bits of each round (index >= P) are zeroed once at job capture
  always_comb begin
    meas_masked = '0;
    for (int u = 0; u < GRID_WIDTH_U; u++) begin
      for (int k = 0; k < MB * 8; k++) begin
        if (k < P) meas_masked[u * MB * 8 + k] = job_meas[u * MB * 8 + k];
      end
    end
  end

  assign job_ready = reset_n && (state_q == ST_IDLE);
  assign rx_ready  = (state_q == ST_RX_RESP);
  assign busy      = (state_q != ST_IDLE);
  assign tx_hs     = tx_valid_q && tx_ready;
  assign rx_hs     = rx_ready && rx_valid;

  assign corr_idx   = rx_cnt_q - RXW'(3);
  assign corr_round = RNDW'(corr_idx / RXW'(CB));
  assign corr_byte  = BYW'(corr_idx % RXW'(CB));

  always_comb begin
    state_d      = state_q;
    meas_d       = meas_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    tx_cnt_d     = tx_cnt_q;
    rx_cnt_d     = rx_cnt_q;
    res_iter_d   = res_iter_q;
    res_cycles_d = res_cycles_q;
    res_valid_d  = res_valid_q;
    corr_clear   = 1'b0;
    corr_wr      = 1'b0;
`ifdef HOST_LINK_TIMEOUT_EN
    wdog_d       = wdog_q;
    res_tout_d   = res_tout_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (job_valid) begin
          meas_d       = meas_masked;
          tx_valid_d   = 1'b1;
          res_iter_d   = '0;
          res_cycles_d = '0;
          corr_clear   = 1'b1;
`ifdef HOST_LINK_TIMEOUT_EN
          res_tout_d   = 1'b0;
`endif
          if (cfg_send_start) begin
            state_d   = ST_TX_START;
            tx_data_d = START_DECODING_MSG;
          end else begin
            state_d   = ST_TX_HDR;
            tx_data_d = MEASUREMENT_DATA_HEADER;
          end
        end
      end
      ST_TX_START: begin
        if (tx_hs) begin
          state_d   = ST_TX_HDR;
          tx_data_d = MEASUREMENT_DATA_HEADER;
        end
      end
      ST_TX_HDR: begin
        if (tx_hs) begin
          state_d   = ST_TX_MEAS;
          tx_data_d = meas_q[7:0];
          tx_cnt_d  = '0;
        end
      end
      ST_TX_MEAS: begin
        if (tx_hs) begin
          if (tx_cnt_q == TX_LAST) begin
            state_d    = ST_RX_RESP;
            tx_valid_d = 1'b0;
            tx_data_d  = '0;
            tx_cnt_d   = '0;
            rx_cnt_d   = '0;
`ifdef HOST_LINK_TIMEOUT_EN
            wdog_d     = '0;
`endif
          end else begin
            tx_cnt_d  = tx_cnt_q + 1'b1;
            tx_data_d = meas_q[8 * (int'(tx_cnt_q) + 1) +: 8];
          end
        end
      end
      ST_RX_RESP: begin
        if (rx_hs) begin
          case (rx_cnt_q)
            RXW'(0): res_iter_d         = rx_data;
            RXW'(1): res_cycles_d[15:8] = rx_data;
            RXW'(2): res_cycles_d[7:0]  = rx_data;
            default: corr_wr            = 1'b1;
          endcase
`ifdef HOST_LINK_TIMEOUT_EN
          wdog_d = '0;
`endif
          if (rx_cnt_q == RX_LAST) begin
            state_d     = ST_RESULT;
            res_valid_d = 1'b1;
            rx_cnt_d    = '0;
          end else begin
            rx_cnt_d = rx_cnt_q + 1'b1;
          end
        end
`ifdef HOST_LINK_TIMEOUT_EN
        // Abort with whatever partial response has arrived so far
        else if (wdog_q == WD_LIMIT) begin
          state_d     = ST_RESULT;
          res_valid_d = 1'b1;
          res_tout_d  = 1'b1;
          rx_cnt_d    = '0;
          wdog_d      = '0;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
`endif
      end
      ST_RESULT: begin
        if (res_ready) begin
          state_d     = ST_IDLE;
          res_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      meas_q       <= '0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      tx_cnt_q     <= '0;
      rx_cnt_q     <= '0;
      res_iter_q   <= '0;
      res_cycles_q <= '0;
      res_valid_q  <= 1'b0;
`ifdef HOST_LINK_TIMEOUT_EN
      wdog_q       <= '0;
      res_tout_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      meas_q       <= meas_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      tx_cnt_q     <= tx_cnt_d;
      rx_cnt_q     <= rx_cnt_d;
      res_iter_q   <= res_iter_d;
      res_cycles_q <= res_cycles_d;
      res_valid_q  <= res_valid_d;
`ifdef HOST_LINK_TIMEOUT_EN
      wdog_q       <= wdog_d;
      res_tout_q   <= res_tout_d;
`endif
    end
  end

  host_link_byte_unpacker #(
    .GRID_WIDTH_X (GRID_WIDTH_X),
    .GRID_WIDTH_Z (GRID_WIDTH_Z),
    .GRID_WIDTH_U (GRID_WIDTH_U),
    .RNDW         (RNDW),
    .BYW          (BYW)
  ) u_unpacker (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (corr_clear),
    .wr_en     (corr_wr),
    .round_idx (corr_round),
    .byte_idx  (corr_byte),
    .data      (rx_data),
    .corr      (res_corr)
  );

  assign tx_data        = tx_data_q;
  assign tx_valid       = tx_valid_q;
  assign res_valid      = res_valid_q;
  assign res_iterations = res_iter_q;
  assign res_cycles     = res_cycles_q;
`ifdef HOST_LINK_TIMEOUT_EN
  assign res_timeout    = res_tout_q;
`else
  assign res_timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_decoder_host_link.sv
// Directed bench for decoder_host_link (X=4, Z=1, U=3); the watchdog scenario
// runs only when HOST_LINK_TIMEOUT_EN is defined.
module tb_decoder_host_link;
  import host_link_pkg::*;

  localparam int MW = 24;
  localparam int CW = 33;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          job_valid = 1'b0;
  logic          job_ready;
  logic [MW-1:0] job_meas = '0;
  logic          cfg_send_start = 1'b0;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [7:0]    res_iterations;
  logic [15:0]   res_cycles;
  logic [CW-1:0] res_corr;
  logic          res_timeout;
  logic          busy;

  int n_eval = 0;
  int n_fail = 0;
  logic [7:0] tx_log [0:15];
  int tx_n;
  logic [7:0] rx_bytes [0:8];

  always #5 clk = ~clk;

  decoder_host_link #(
    .GRID_WIDTH_X(4), .GRID_WIDTH_Z(1), .GRID_WIDTH_U(3), .RESP_TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .job_valid(job_valid), .job_ready(job_ready), .job_meas(job_meas),
    .cfg_send_start(cfg_send_start),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_iterations(res_iterations), .res_cycles(res_cycles), .res_corr(res_corr),
    .res_timeout(res_timeout), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_eval++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_job(input logic [MW-1:0] meas, input logic start);
    @(negedge clk);
    chk("job_ready_idle", 64'(job_ready), 64'd1);
    job_valid      = 1'b1;
    job_meas       = meas;
    cfg_send_start = start;
    @(negedge clk);
    job_valid = 1'b0;
    chk("busy_after_accept", 64'(busy), 64'd1);
    chk("tx_valid_after_accept", 64'(tx_valid), 64'd1);
    chk("rx_ready_during_tx", 64'(rx_ready), 64'd0);
  endtask

  // Collect n bytes; with rnd set, tx_ready toggles randomly and stalled bytes must hold
  task automatic collect_tx(input int n, input bit rnd);
    int cyc = 0;
    bit stalled = 1'b0;
    logic [7:0] held = '0;
    tx_n = 0;
    while (tx_n < n && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (stalled) begin
        chk("tx_valid_hold", 64'(tx_valid), 64'd1);
        chk("tx_data_hold", 64'(tx_data), 64'(held));
      end
      tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled = 1'b0;
      if (tx_valid) begin
        if (tx_ready) begin
          tx_log[tx_n] = tx_data;
          tx_n++;
        end else begin
          stalled = 1'b1;
          held    = tx_data;
        end
      end
    end
    chk("tx_byte_count", 64'(tx_n), 64'(n));
  endtask

  task automatic end_tx();
    @(negedge clk);
    tx_ready = 1'b0;
    chk("tx_valid_after_last", 64'(tx_valid), 64'd0);
    chk("rx_ready_in_rx", 64'(rx_ready), 64'd1);
  endtask

  task automatic send_rx(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("rx_ready_per_byte", 64'(rx_ready), 64'd1);
      rx_valid = 1'b1;
      rx_data  = rx_bytes[i];
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic check_result(input logic [7:0] it, input logic [15:0] cy,
                              input logic [CW-1:0] corr, input logic tout);
    chk("res_valid", 64'(res_valid), 64'd1);
    chk("res_iterations", 64'(res_iterations), 64'(it));
    chk("res_cycles", 64'(res_cycles), 64'(cy));
    chk("res_corr", 64'(res_corr), 64'(corr));
    chk("res_timeout", 64'(res_timeout), 64'(tout));
    chk("rx_ready_in_result", 64'(rx_ready), 64'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      res_ready = 1'b0;
      chk("res_valid_stall", 64'(res_valid), 64'd1);
      chk("res_corr_stall", 64'(res_corr), 64'(corr));
      chk("job_ready_stall", 64'(job_ready), 64'd0);
    end
    @(negedge clk);
    res_ready = 1'b1;
    chk("job_ready_in_handshake", 64'(job_ready), 64'd0);
    @(negedge clk);
    res_ready = 1'b0;
    chk("res_valid_cleared", 64'(res_valid), 64'd0);
    chk("job_ready_after_handshake", 64'(job_ready), 64'd1);
    chk("busy_after_handshake", 64'(busy), 64'd0);
  endtask

  task automatic load_rx_std();
    rx_bytes[0] = 8'h07; rx_bytes[1] = 8'h01; rx_bytes[2] = 8'h2C;
    rx_bytes[3] = 8'h34; rx_bytes[4] = 8'h05; rx_bytes[5] = 8'h12;
    rx_bytes[6] = 8'h00; rx_bytes[7] = 8'hFF; rx_bytes[8] = 8'h07;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_job_ready", 64'(job_ready), 64'd0);
    chk("rst_tx_valid", 64'(tx_valid), 64'd0);
    chk("rst_tx_data", 64'(tx_data), 64'd0);
    chk("rst_rx_ready", 64'(rx_ready), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_corr", 64'(res_corr), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_job_ready", 64'(job_ready), 64'd1);
    chk("idle_rx_ready", 64'(rx_ready), 64'd0);

    // Basic job, no start message, full-rate link
    send_job(24'h0F0A05, 1'b0);
    collect_tx(4, 1'b0);
    chk("t1_b0", 64'(tx_log[0]), 64'(MEASUREMENT_DATA_HEADER));
    chk("t1_b1", 64'(tx_log[1]), 64'h05);
    chk("t1_b2", 64'(tx_log[2]), 64'h0A);
    chk("t1_b3", 64'(tx_log[3]), 64'h0F);
    end_tx();
    load_rx_std();
    send_rx(9);
    check_result(8'h07, 16'h012C, {11'h7FF, 11'h012, 11'h534}, 1'b0);

    // Pad bits masked, random tx back-pressure, second response pattern
    send_job(24'hFFA5F3, 1'b0);
    collect_tx(4, 1'b1);
    chk("t2_b0", 64'(tx_log[0]), 64'(MEASUREMENT_DATA_HEADER));
    chk("t2_b1", 64'(tx_log[1]), 64'h03);
    chk("t2_b2", 64'(tx_log[2]), 64'h05);
    chk("t2_b3", 64'(tx_log[3]), 64'h0F);
    end_tx();
    rx_bytes[0] = 8'h01; rx_bytes[1] = 8'h00; rx_bytes[2] = 8'h05;
    rx_bytes[3] = 8'hFF; rx_bytes[4] = 8'hFF; rx_bytes[5] = 8'h00;
    rx_bytes[6] = 8'h08; rx_bytes[7] = 8'hAB; rx_bytes[8] = 8'hCD;
    send_rx(9);
    check_result(8'h01, 16'h0005, {11'h5AB, 11'h000, 11'h7FF}, 1'b0);

    // Start message first, random back-pressure
    send_job(24'h0C0301, 1'b1);
    collect_tx(5, 1'b1);
    chk("t3_b0", 64'(tx_log[0]), 64'(START_DECODING_MSG));
    chk("t3_b1", 64'(tx_log[1]), 64'(MEASUREMENT_DATA_HEADER));
    chk("t3_b2", 64'(tx_log[2]), 64'h01);
    chk("t3_b3", 64'(tx_log[3]), 64'h03);
    chk("t3_b4", 64'(tx_log[4]), 64'h0C);
    end_tx();
    load_rx_std();
    send_rx(9);
    check_result(8'h07, 16'h012C, {11'h7FF, 11'h012, 11'h534}, 1'b0);

    // Reset in the middle of the measurement bytes
    send_job(24'h0F0A05, 1'b0);
    collect_tx(2, 1'b0);
    @(negedge clk);
    tx_ready = 1'b0;
    reset_n  = 1'b0;
    #1;
    chk("mid_rst_tx_valid", 64'(tx_valid), 64'd0);
    chk("mid_rst_tx_data", 64'(tx_data), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_job_ready", 64'(job_ready), 64'd0);
    chk("mid_rst_rx_ready", 64'(rx_ready), 64'd0);
    chk("mid_rst_res_valid", 64'(res_valid), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    send_job(24'h0F0A05, 1'b0);
    collect_tx(4, 1'b0);
    chk("t7_b0", 64'(tx_log[0]), 64'(MEASUREMENT_DATA_HEADER));
    chk("t7_b1", 64'(tx_log[1]), 64'h05);
    chk("t7_b3", 64'(tx_log[3]), 64'h0F);
    end_tx();
    load_rx_std();
    send_rx(9);
    check_result(8'h07, 16'h012C, {11'h7FF, 11'h012, 11'h534}, 1'b0);

`ifdef HOST_LINK_TIMEOUT_EN
    // Response stops after the first round's correction bytes
    send_job(24'h0F0A05, 1'b0);
    collect_tx(4, 1'b0);
    end_tx();
    load_rx_std();
    send_rx(5);
    chk("wd_res_valid_0", 64'(res_valid), 64'd0);
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      chk("wd_res_valid_wait", 64'(res_valid), 64'd0);
    end
    @(negedge clk);
    check_result(8'h07, 16'h012C, {11'h000, 11'h000, 11'h534}, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
    $finish;
  end

endmodule
